// File: rtl/fetch_unit.sv
// Instruction-fetch control: issues one outstanding imem read at PcQ, steers the PC register's D
// input, and hands fetched words to decode through a valid/ready register with a one-entry skid.
module fetch_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PcQ,
  output logic [31:0] PcD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic        id_valid_q;
  logic [31:0] id_instr_q, id_pc_q;
  logic [31:0] skid_instr_q, skid_pc_q;

  logic redirect;
  logic out_free;
  logic rsp_take;
  logic load_out, load_skid, skid_to_out;

  // Redirects are ignored only in the single post-reset idle cycle.
  assign redirect = redirect_valid && (state_q != StIdle);
  assign out_free = !id_valid_q || id_ready;
  assign rsp_take = (state_q == StWait) && imem_rvalid && !redirect_valid;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq:  state_d = redirect_valid ? StReq : StWait;
      StWait: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? StReq : StDrop;
        end else if (imem_rvalid) begin
          state_d = out_free ? StReq : StHold;
        end
      end
      StHold: begin
        if (redirect_valid || id_ready) begin
          state_d = StReq;
        end
      end
      StDrop: begin
        // A redirect while draining keeps waiting for the stale response.
        if (!redirect_valid && imem_rvalid) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == StReq) && !redirect_valid;
    imem_addr   = imem_req ? PcQ : 32'h0;
    load_out    = rsp_take && out_free;
    load_skid   = rsp_take && !out_free;
    skid_to_out = (state_q == StHold) && id_ready && !redirect_valid;
    if (redirect) begin
      PcD = {redirect_target[31:2], 2'b00};
    end else if (rsp_take) begin
      PcD = PcQ + 32'd4;
    end else begin
      PcD = PcQ;
    end
  end

  // Skid occupancy is implied by StHold, so only its payload is stored here.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'h0;
      id_pc_q      <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
    end else begin
      if (redirect) begin
        id_valid_q <= 1'b0;
      end else if (load_out) begin
        id_valid_q <= 1'b1;
        id_instr_q <= imem_rdata;
        id_pc_q    <= PcQ;
      end else if (skid_to_out) begin
        id_valid_q <= 1'b1;
        id_instr_q <= skid_instr_q;
        id_pc_q    <= skid_pc_q;
      end else if (id_valid_q && id_ready) begin
        id_valid_q <= 1'b0;
      end
      if (load_skid) begin
        skid_instr_q <= imem_rdata;
        skid_pc_q    <= PcQ;
      end
    end
  end

  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;
  assign id_pc4   = id_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: per-cycle input rows with hand-computed outputs,
// plus hand-written reset sequences.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PcQ, PcD;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, id_pc4;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .PcQ             (PcQ),
    .PcD             (PcD),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc4          (id_pc4)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        redir;
    logic [31:0] tgt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic [31:0] pcq;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pcd;
    logic        e_idv;
    logic [31:0] e_instr;
    logic [31:0] e_idpc;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] InA = 32'h20080005;
  localparam logic [31:0] InB = 32'h11111111;
  localparam logic [31:0] InC = 32'h22222222;
  localparam logic [31:0] InD = 32'h33333333;
  localparam logic [31:0] InF = 32'h44444444;
  localparam logic [31:0] Junk = 32'hDEADBEEF;

  task automatic add(input logic redir, input logic [31:0] tgt, input logic rv,
                     input logic [31:0] rdata, input logic rdy, input logic [31:0] pcq,
                     input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pcd,
                     input logic e_idv, input logic [31:0] e_instr, input logic [31:0] e_idpc);
    vec_t v;
    v.redir = redir; v.tgt = tgt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.pcq = pcq;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pcd = e_pcd;
    v.e_idv = e_idv; v.e_instr = e_instr; v.e_idpc = e_idpc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, " imem_addr"}, imem_addr, 32'd0);
    chk({tag, " id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, " id_instr"}, id_instr, 32'd0);
    chk({tag, " id_pc"}, id_pc, 32'd0);
    chk({tag, " PcD"}, PcD, PcQ);
  endtask

  initial begin
    // Basic fetch, then a 6-cycle decode stall across two fetches (c3..c8).
    add(0, 0, 1, Junk, 1, 32'h0,  0, 0,     32'h0, 0, 0,   0);     // c0 idle, rvalid ignored
    add(0, 0, 0, 0,    1, 32'h0,  1, 32'h0, 32'h0, 0, 0,   0);     // c1 req
    add(0, 0, 1, InA,  1, 32'h0,  0, 0,     32'h4, 0, 0,   0);     // c2 wait+rsp
    add(0, 0, 0, 0,    0, 32'h4,  1, 32'h4, 32'h4, 1, InA, 32'h0); // c3
    add(0, 0, 1, InB,  0, 32'h4,  0, 0,     32'h8, 1, InA, 32'h0); // c4 -> skid
    add(0, 0, 0, 0,    0, 32'h8,  0, 0,     32'h8, 1, InA, 32'h0); // c5 hold
    add(0, 0, 1, Junk, 0, 32'h8,  0, 0,     32'h8, 1, InA, 32'h0); // c6 stray rvalid
    add(0, 0, 0, 0,    0, 32'h8,  0, 0,     32'h8, 1, InA, 32'h0); // c7
    add(0, 0, 0, 0,    0, 32'h8,  0, 0,     32'h8, 1, InA, 32'h0); // c8
    add(0, 0, 0, 0,    1, 32'h8,  0, 0,     32'h8, 1, InA, 32'h0); // c9 A taken
    add(0, 0, 0, 0,    1, 32'h8,  1, 32'h8, 32'h8, 1, InB, 32'h4); // c10 B taken
    add(0, 0, 1, InC,  1, 32'h8,  0, 0,     32'hC, 0, 0,   0);     // c11
    add(0, 0, 0, 0,    1, 32'hC,  1, 32'hC, 32'hC, 1, InC, 32'h8); // c12
    // Redirect in WAIT with the response 3 cycles later.
    add(1, 32'h00400023, 0, 0, 1, 32'hC, 0, 0, 32'h00400020, 0, 0, 0);      // c13
    add(0, 0, 0, 0,    1, 32'h00400020, 0, 0, 32'h00400020, 0, 0, 0);       // c14 drop
    add(0, 0, 0, 0,    1, 32'h00400020, 0, 0, 32'h00400020, 0, 0, 0);       // c15
    add(0, 0, 1, Junk, 1, 32'h00400020, 0, 0, 32'h00400020, 0, 0, 0);       // c16 discarded
    add(0, 0, 0, 0,    1, 32'h00400020, 1, 32'h00400020, 32'h00400020, 0, 0, 0);
    // Redirect coincident with rvalid while id_valid=1.
    add(0, 0, 1, InD,  1, 32'h00400020, 0, 0, 32'h00400024, 0, 0, 0);       // c18
    add(0, 0, 0, 0,    0, 32'h00400024, 1, 32'h00400024, 32'h00400024, 1, InD, 32'h00400020);
    add(1, 32'h00001000, 1, Junk, 1, 32'h00400024, 0, 0, 32'h00001000, 1, InD, 32'h00400020);
    add(0, 0, 0, 0,    1, 32'h00001000, 1, 32'h00001000, 32'h00001000, 0, 0, 0); // c21
    // Wrap at the top of the address space.
    add(1, 32'hFFFFFFFF, 0, 0, 1, 32'h00001000, 0, 0, 32'hFFFFFFFC, 0, 0, 0); // c22
    add(0, 0, 1, Junk, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 0, 0, 0);         // c23
    add(0, 0, 0, 0,    1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0, 0);
    add(0, 0, 1, InF,  0, 32'hFFFFFFFC, 0, 0, 32'h0, 0, 0, 0);                // c25
    add(0, 0, 0, 0,    0, 32'h0, 1, 32'h0, 32'h0, 1, InF, 32'hFFFFFFFC);      // c26
    add(0, 0, 0, 0,    0, 32'h0, 0, 0,     32'h0, 1, InF, 32'hFFFFFFFC);      // c27 wait

    Reset = 1'b0;
    PcQ = 32'h00001234;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    id_ready = 1'b1;
    #1;
    chk_reset_outputs("init-reset");
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_reset_outputs("held-reset");

    foreach (vecs[i]) begin
      @(posedge Clk);
      #1;
      if (i == 0) Reset = 1'b1;
      redirect_valid  = vecs[i].redir;
      redirect_target = vecs[i].tgt;
      imem_rvalid     = vecs[i].rv;
      imem_rdata      = vecs[i].rdata;
      id_ready        = vecs[i].rdy;
      PcQ             = vecs[i].pcq;
      @(negedge Clk);
      chk($sformatf("c%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("c%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("c%0d PcD", i), PcD, vecs[i].e_pcd);
      chk($sformatf("c%0d id_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].e_idv});
      if (vecs[i].e_idv) begin
        chk($sformatf("c%0d id_instr", i), id_instr, vecs[i].e_instr);
        chk($sformatf("c%0d id_pc", i), id_pc, vecs[i].e_idpc);
        chk($sformatf("c%0d id_pc4", i), id_pc4, vecs[i].e_idpc + 32'd4);
      end
    end

    // Reset mid-WAIT: outputs clear immediately; response arrives in reset and in IDLE.
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    PcQ = 32'h00000080;
    redirect_valid = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk_reset_outputs("async-reset");
    @(posedge Clk);
    #1;
    imem_rvalid = 1'b1; imem_rdata = Junk;
    @(negedge Clk);
    chk_reset_outputs("reset-rsp");
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(negedge Clk);
    chk_reset_outputs("idle-rsp");
    @(posedge Clk);
    #1;
    imem_rvalid = 1'b0; id_ready = 1'b1;
    @(negedge Clk);
    chk("restart imem_req", {31'd0, imem_req}, 32'd1);
    chk("restart imem_addr", imem_addr, 32'h00000080);
    chk("restart id_valid", {31'd0, id_valid}, 32'd0);
    @(posedge Clk);
    #1;
    imem_rvalid = 1'b1; imem_rdata = 32'h55555555;
    @(negedge Clk);
    chk("restart PcD", PcD, 32'h00000084);
    @(posedge Clk);
    #1;
    imem_rvalid = 1'b0; PcQ = 32'h00000084;
    @(negedge Clk);
    chk("restart id_valid", {31'd0, id_valid}, 32'd1);
    chk("restart id_instr", id_instr, 32'h55555555);
    chk("restart id_pc", id_pc, 32'h00000080);
    chk("restart id_pc4", id_pc4, 32'h00000084);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch control stage sitting directly upstream of the PC register and downstream of it at once: it consumes the PC register's current value (Q), issues the instruction-memory read for that address, and drives the PC register's next value (D) every cycle. Fetched instructions are delivered to decode through a valid/ready output register with a one-entry skid buffer. Branch/jump redirects from later stages flush fetch and steer the PC.

## Interface
Parameters:
- none. All address and instruction widths are fixed at 32 bits.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- PcQ  input  32  current PC register value; this is the address of the next instruction to fetch.
- PcD  output  32  next PC register value; combinational.
- imem_req  output  1  read request strobe; one-cycle pulse.
- imem_addr  output  32  read address; equals PcQ while imem_req=1, else 0.
- imem_rvalid  input  1  read data valid; one-cycle pulse, arrives at least 1 cycle after imem_req.
- imem_rdata  input  32  instruction word; qualified by imem_rvalid.
- redirect_valid  input  1  redirect request from branch/jump resolution.
- redirect_target  input  32  redirect address.
- id_valid  output  1  output register holds an instruction.
- id_ready  input  1  decode accepts; transfer when id_valid & id_ready.
- id_instr  output  32  instruction word.
- id_pc  output  32  address of id_instr.
- id_pc4  output  32  id_pc + 4, modulo 2^32.

## Operation
- At most one memory request is outstanding at any time.
- The FSM has five states:
  - IDLE: one cycle after reset release; any imem_rvalid is ignored; goes to REQ.
  - REQ: drives imem_req=1 and imem_addr=PcQ, then goes to WAIT. If redirect_valid is high, imem_req is suppressed and the FSM stays in REQ.
  - WAIT: on imem_rvalid with the output register free (id_valid=0, or id_valid & id_ready this cycle):
    - load id_instr=imem_rdata and id_pc=PcQ; set id_valid=1; go to REQ.
  - WAIT: on imem_rvalid with the output register busy and not draining:
    - capture the instruction and PcQ into the skid buffer; go to HOLD.
  - HOLD: when id_ready, move the skid buffer into the output register (id_valid stays 1); go to REQ.
  - DROP: the next imem_rvalid is discarded; then go to REQ.
- PcD priority:
  - redirect_valid → {redirect_target[31:2], 2'b00};
  - else an instruction accepted from memory this cycle (into the output register or skid buffer) → PcQ + 4;
  - else → PcQ (hold).
- Redirect, in any state except IDLE:
  - id_valid and the skid buffer are cleared next cycle; a transfer in the redirect cycle does not occur.
  - In WAIT without imem_rvalid → DROP.
  - In WAIT with simultaneous imem_rvalid → the data is discarded, go to REQ.
  - In DROP → stay in DROP.
  - In HOLD → go to REQ.
- id_pc4 wraps: id_pc=0xFFFFFFFC gives id_pc4=0x00000000.
- While id_valid=1 and id_ready=0, id_instr, id_pc and id_pc4 are held stable.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; imem_req=0; id_valid=0; id_instr=0x00000000; id_pc=0; skid buffer empty.
  - PcD=PcQ throughout reset and in IDLE.
- Reset asserted mid-operation aborts everything: an outstanding response is dropped (seen in IDLE or never), and no state survives.
- Latency with 1-cycle memory:
  - request in cycle n, rvalid in n+1, id_valid=1 and PcQ advanced in n+2, next request in n+2.
  - Throughput is one instruction per 2 cycles.
- Redirect latency: PcQ = redirect target one cycle after redirect_valid; the first request to the target is issued that cycle when no response is pending.
- imem_rvalid in REQ or HOLD is a protocol violation (no request outstanding); it is ignored.

## Test plan
- Reset release with PcQ=0 and 1-cycle memory returning 0x20080005 → imem_req in cycle 1 with addr 0; id_valid=1, id_instr=0x20080005, id_pc=0, id_pc4=4 in cycle 3; PcD=4 in cycle 2.
- Decode stalls (id_ready=0) for 6 cycles across two fetches → second instruction sits in HOLD; id_instr stays stable; both instructions are delivered in order and PC advances by exactly 8.
- redirect_valid with target 0x00400023 while in WAIT, response arriving 3 cycles later → the response is discarded; PcD=0x00400020; the next imem_addr=0x00400020.
- redirect_valid coincident with imem_rvalid and id_valid=1 → data dropped, id_valid=0 next cycle, no PC+4, request to the target follows.
- id_pc=0xFFFFFFFC fetched → id_pc4=0x00000000; next PcD=0x00000000.
- Reset asserted during WAIT, response arriving in reset/IDLE → all outputs return to reset values immediately; the response is ignored; fetch restarts at PcQ.
